alu_muldiv_control: RTL and testbench

Parametrised successor to the multicycle CPU's ALU control decoder. It keeps the combinational ALUOp/funct → ALUControl decode and adds a sequenced HI/LO unit for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide run as iterative shift-add and restoring-divide operations over WIDTH cycles. The block sits beside the ALU in the execute stage, and the main control FSM stalls on `busy`.

---
 rtl/alu_muldiv_control.sv | 189 ++++++++++++++++++
 tb/tb_alu_muldiv_control.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_control.sv
// alu_muldiv_control: ALU control decode plus a sequenced HI/LO unit.
//   Decode (combinational): ALUOp/funct -> ALUControl.
//   HI/LO unit: MTHI/MTLO complete in one edge. MULT/MULTU/DIV/DIVU each take
//   WIDTH+2 edges: iterative shift-add multiply, or restoring divide.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ALUOp, funct, start   decode inputs and issue strobe from the main FSM
//   src_a, src_b          rs/rt operands, captured on accept
//   ALUControl            combinational ALU select
//   busy, done            operation in flight / one-cycle completion pulse
//   hi, lo, div_by_zero   HI/LO registers and sticky divide-by-zero flag
module alu_muldiv_control #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        funct,
  input  logic              start,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              div_by_zero
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIX} state_t;

  state_t             state;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   acc;     // product upper half, or partial remainder
  logic [WIDTH-1:0]   q;       // multiplier bits, or dividend/quotient bits
  logic [WIDTH-1:0]   m;       // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_q;   // negate product / quotient at FIX
  logic               neg_r;   // negate remainder at FIX
  logic               dz;

  // ALU select decode
  always_comb begin
    ALUControl = CTRL_W'(4'b0010);
    case (ALUOp)
      2'b01: ALUControl = CTRL_W'(4'b0110);
      2'b10: begin
        case (funct)
          6'h20, 6'h21: ALUControl = CTRL_W'(4'b0010);
          6'h22, 6'h23: ALUControl = CTRL_W'(4'b0110);
          6'h24:        ALUControl = CTRL_W'(4'b0000);
          6'h25:        ALUControl = CTRL_W'(4'b0001);
          6'h26:        ALUControl = CTRL_W'(4'b0011);
          6'h27:        ALUControl = CTRL_W'(4'b0100);
          6'h2A:        ALUControl = CTRL_W'(4'b0111);
          6'h2B:        ALUControl = CTRL_W'(4'b1000);
          6'h00:        ALUControl = CTRL_W'(4'b1001);
          6'h02:        ALUControl = CTRL_W'(4'b1010);
          6'h03:        ALUControl = CTRL_W'(4'b1011);
          default:      ALUControl = CTRL_W'(4'b0010);
        endcase
      end
      default: ALUControl = CTRL_W'(4'b0010);
    endcase
  end

  // Accept qualification and operand magnitudes (funct[0]=0 marks signed ops)
  logic             accept_c;
  logic             is_mt_c;
  logic             sgn_c;
  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;

  always_comb begin
    accept_c = start && (state == S_IDLE) && (ALUOp == 2'b10) &&
               (funct inside {6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
    is_mt_c  = (funct == 6'h11) || (funct == 6'h13);
    sgn_c    = ~funct[0];
    abs_a_c  = (sgn_c && src_a[WIDTH-1]) ? ('0 - src_a) : src_a;
    abs_b_c  = (sgn_c && src_b[WIDTH-1]) ? ('0 - src_b) : src_b;
  end

  // One iteration step: shift-add multiply or restoring divide
  logic [WIDTH:0]   add_sum_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH-1:0] diff_c;
  logic             ge_c;
  logic [WIDTH-1:0] step_acc_c;
  logic [WIDTH-1:0] step_q_c;

  always_comb begin
    add_sum_c = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shifted_c = {acc, q[WIDTH-1]};
    ge_c      = (shifted_c >= {1'b0, m});
    // True difference is below m whenever ge holds, so WIDTH bits suffice
    diff_c    = shifted_c[WIDTH-1:0] - m;
    if (is_div) begin
      step_acc_c = ge_c ? diff_c : shifted_c[WIDTH-1:0];
      step_q_c   = {q[WIDTH-2:0], ge_c};
    end else begin
      step_acc_c = add_sum_c[WIDTH:1];
      step_q_c   = {add_sum_c[0], q[WIDTH-1:1]};
    end
  end

  // Sign correction applied at FIX
  logic [PW-1:0]    prod_fix_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic [WIDTH-1:0] rem_fix_c;

  always_comb begin
    prod_fix_c = neg_q ? ('0 - {acc, q}) : {acc, q};
    quo_fix_c  = neg_q ? ('0 - q) : q;
    rem_fix_c  = neg_r ? ('0 - acc) : acc;
  end

  // Sequencer and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            div_by_zero <= 1'b0;
            if (is_mt_c) begin
              if (funct == 6'h11) hi <= src_a;
              else                lo <= src_a;
              done <= 1'b1;
            end else begin
              state  <= S_LOAD;
              busy   <= 1'b1;
              is_div <= funct[1];
              neg_q  <= sgn_c & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              neg_r  <= sgn_c & src_a[WIDTH-1];
              dz     <= funct[1] && (src_b == '0);
              acc    <= '0;
              q      <= funct[1] ? abs_a_c : abs_b_c;
              m      <= funct[1] ? abs_b_c : abs_a_c;
            end
          end
        end
        S_LOAD: begin
          cnt   <= WIDTH'(WIDTH);
          state <= S_RUN;
        end
        S_RUN: begin
          acc <= step_acc_c;
          q   <= step_q_c;
          cnt <= cnt - WIDTH'(1);
          if (cnt == WIDTH'(1)) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            // With a zero divisor the remainder path reproduces src_a
            hi          <= rem_fix_c;
            lo          <= dz ? '1 : quo_fix_c;
            div_by_zero <= dz;
          end else begin
            hi <= prod_fix_c[PW-1:WIDTH];
            lo <= prod_fix_c[WIDTH-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Directed testbench for alu_muldiv_control (WIDTH=32, CTRL_W=4).
module tb_alu_muldiv_control;

  logic        clk;
  logic        rst;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic        start;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  ALUControl;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  alu_muldiv_control #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .rst(rst), .ALUOp(ALUOp), .funct(funct), .start(start),
    .src_a(src_a), .src_b(src_b), .ALUControl(ALUControl), .busy(busy),
    .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue a MULT/DIV-class op, measure busy length, then check results
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz);
    int cyc;
    logic overlap;
    @(negedge clk);
    ALUOp = 2'b10; funct = f; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; src_a = ~a; src_b = ~b;   // operands must already be captured
    cyc = 0;
    overlap = 1'b0;
    @(negedge clk);
    while (busy && cyc < 100) begin
      if (done) overlap = 1'b1;
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(cyc), 64'd34);
    chk({tag, "_done_while_busy"}, 64'(overlap), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 64'(done), 64'd0);
  endtask

  // Issue MTHI/MTLO and check the one-edge update
  task automatic mt_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    ALUOp = 2'b10; funct = f; src_a = a; src_b = 32'h0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_dz"}, 64'(div_by_zero), 64'd0);
  endtask

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] c;
  } dec_t;

  dec_t dec_tab [0:17];

  initial begin
    int n;
    logic seen_done;
    dec_tab = '{
      '{2'b00, 6'h00, 4'h2}, '{2'b01, 6'h00, 4'h6}, '{2'b11, 6'h00, 4'h2},
      '{2'b10, 6'h20, 4'h2}, '{2'b10, 6'h21, 4'h2}, '{2'b10, 6'h22, 4'h6},
      '{2'b10, 6'h23, 4'h6}, '{2'b10, 6'h24, 4'h0}, '{2'b10, 6'h25, 4'h1},
      '{2'b10, 6'h26, 4'h3}, '{2'b10, 6'h27, 4'h4}, '{2'b10, 6'h2A, 4'h7},
      '{2'b10, 6'h2B, 4'h8}, '{2'b10, 6'h00, 4'h9}, '{2'b10, 6'h02, 4'hA},
      '{2'b10, 6'h03, 4'hB}, '{2'b10, 6'h3F, 4'h2}, '{2'b10, 6'h18, 4'h2}
    };

    rst = 1'b1; ALUOp = 2'b00; funct = 6'h00; start = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);

    // Decode sweep
    for (int i = 0; i < 18; i++) begin
      ALUOp = dec_tab[i].op;
      funct = dec_tab[i].f;
      #1;
      chk($sformatf("dec_op%0d_f%02h", dec_tab[i].op, dec_tab[i].f),
          64'(ALUControl), 64'(dec_tab[i].c));
    end

    // Start with a non-HI/LO funct is ignored
    @(negedge clk);
    ALUOp = 2'b10; funct = 6'h20; src_a = 32'h1234; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("ign_busy", 64'(busy), 64'd0);
    chk("ign_done", 64'(done), 64'd0);
    chk("ign_hi", 64'(hi), 64'd0);

    run_op("mult", 6'h18, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("multu", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("divu", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_neg", 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
    run_op("div_zero", 6'h1A, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1);
    mt_op("mtlo", 6'h13, 32'd5, 32'd9, 32'd5);
    mt_op("mthi", 6'h11, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd5);

    // Second start at E3 while busy must be ignored
    @(negedge clk);
    ALUOp = 2'b10; funct = 6'h18; src_a = 32'hFFFFFFFD; src_b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    funct = 6'h19; src_a = 32'd7; src_b = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("midop_done", 64'(done), 64'd1);
    chk("midop_hi", 64'(hi), 64'hFFFFFFFF);
    chk("midop_lo", 64'(lo), 64'hFFFFFFF1);
    @(negedge clk);
    chk("midop_idle", 64'(busy), 64'd0);

    // Reset at E10 of a DIVU aborts it
    @(negedge clk);
    ALUOp = 2'b10; funct = 6'h1B; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);

    run_op("recover", 6'h19, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
